updown_step_counter: RTL
========================

// Module: updown_step_counter
// PURPOSE
//   Parametrised up/down counter with two programmable step sizes, load, enable
//   and three overflow policies: wrap, saturate, bounce (ping-pong).
//   Successor to the fixed 4-bit +1/+2/-1/-2 counter.
//   Used as a general event/address counter in the EDA exercise designs.
// PARAMETERS
//   WIDTH   4  counter width in bits (>=2); MAX = 2**WIDTH-1
//   STEP_A  1  small step; 1 <= STEP_A <= MAX
//   STEP_B  2  large step; 1 <= STEP_B <= MAX
//   MODE    0  0 = wrap, 1 = saturate, 2 = bounce
//   INIT    0  reset value of qout; 0 <= INIT <= MAX
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   reset     in   1      synchronous reset, active-high
//   en        in   1      count enable
//   ctrl      in   2      ctrl[0]: 0=STEP_A, 1=STEP_B; ctrl[1]: 0=up, 1=down (ignored in bounce)
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  value to load
//   qout      out  WIDTH  counter value (registered)
//   ovf       out  1      registered 1-cycle pulse: limit crossed, clamped or reversed
//   dir       out  1      bounce direction register (0=up, 1=down); constant 0 in MODE 0/1
//   at_max    out  1      combinational: qout == MAX
//   at_min    out  1      combinational: qout == 0
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset values: qout = INIT, ovf = 0, dir = 0.
//   - Priority per edge: reset > load > en > hold.
//   - load=1: qout <= load_val; ovf <= 0; dir unchanged; en ignored.
//   - en=0 and load=0: qout and dir hold; ovf <= 0.
//   - Latency: 1 cycle from the sampled inputs to qout/ovf/dir.
//   - step = ctrl[0] ? STEP_B : STEP_A.
//   - All sums are computed in WIDTH+1 bits; no truncation before the overflow decision.
//   - Wrap (MODE 0):
//     - up: qout <= (qout + step) mod 2**WIDTH; ovf = carry out of the WIDTH-bit sum.
//     - down: qout <= (qout - step) mod 2**WIDTH; ovf = borrow (step > qout).
//   - Saturate (MODE 1):
//     - up: qout + step > MAX -> qout <= MAX, ovf = 1; else add, ovf = 0.
//     - down: step > qout -> qout <= 0, ovf = 1; else subtract, ovf = 0.
//     - Sitting at the limit and still pushing outward re-asserts ovf every enabled cycle.
//   - Bounce (MODE 2), direction taken from dir, ctrl[1] ignored:
//     - dir=0: qout + step >= MAX -> qout <= MAX, dir <= 1, ovf = 1; else add.
//     - dir=1: qout <= step -> qout <= 0, dir <= 0, ovf = 1; else subtract.
//     - Exactly landing on a limit also reverses and pulses ovf.
//   - load during bounce keeps dir; counting resumes in the old direction from load_val.
//   - Reset mid-operation: every register returns to its reset value on that edge,
//     regardless of en/load.
//   - at_max/at_min are pure decodes of the registered qout (no extra latency).
// TESTING (WIDTH=4, STEP_A=1, STEP_B=2, INIT=0 unless stated)
//   1 Wrap:
//     - load 15, en=1, ctrl=00 -> qout=0, ovf=1.
//     - ctrl=01 from 15 -> 1, ovf=1.
//     - ctrl=11 from 1 -> 15, ovf=1.
//     - ctrl=10 from 5 -> 4, ovf=0.
//   2 Saturate:
//     - load 14, ctrl=01 -> 15, ovf=1; next cycle 15, ovf=1.
//     - ctrl=11 from 1 -> 0, ovf=1, at_min=1.
//     - ctrl=10 from 3 -> 2, ovf=0.
//   3 Bounce:
//     - load 13, ctrl=01 -> 15, dir=1, ovf=1.
//     - then ctrl=00 -> 14, ovf=0.
//     - from 2, ctrl=01 -> 0, dir=0, ovf=1; next cycle 2.
//   4 Priority: load=1 & en=1, load_val=9 -> qout=9, ovf=0; en=0 holds 9 for 3 cycles, ovf=0.
//   5 Reset mid-count: INIT=7, wrap mode, counting at 12 with load=1 and reset=1 on the same edge
//     -> qout=7, ovf=0, dir=0; counting resumes next cycle.
//   6 Sweep: random ctrl/en/load for 10k cycles against a reference model, all three MODEs,
//     WIDTH=4 and WIDTH=8.

Source files
------------

// File: rtl/updown_step_counter.sv
// Parametrised up/down counter with two step sizes, synchronous load and enable,
// and a selectable limit policy: wrap, saturate or bounce (ping-pong).
module updown_step_counter #(
  parameter int WIDTH  = 4,
  parameter int STEP_A = 1,
  parameter int STEP_B = 2,
  parameter int MODE   = 0,
  parameter int INIT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       ctrl,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] qout,
  output logic             ovf,
  output logic             dir,
  output logic             at_max,
  output logic             at_min
);

  localparam int             MODE_WRAP   = 0;
  localparam int             MODE_SAT    = 1;
  localparam int             MODE_BOUNCE = 2;
  localparam logic [WIDTH:0] MAX_X       = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] STEP_A_X    = (WIDTH+1)'(STEP_A);
  localparam logic [WIDTH:0] STEP_B_X    = (WIDTH+1)'(STEP_B);
  localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};

  // Each policy function returns {flag, value}: flag is the limit event that
  // drives ovf (and, in bounce mode, the direction flip).

  // Modulo add: flag is the carry out of the WIDTH-bit sum.
  function automatic logic [WIDTH:0] wrap_up(input logic [WIDTH:0] sum);
    return sum;
  endfunction

  // Modulo subtract: flag is the borrow, i.e. the top bit of the extended difference.
  function automatic logic [WIDTH:0] wrap_down(input logic [WIDTH:0] diff);
    return diff;
  endfunction

  // Clamp to MAX when the unclamped sum exceeds the range.
  function automatic logic [WIDTH:0] sat_up(input logic [WIDTH:0] sum);
    if (sum > MAX_X) return {1'b1, ALL_ONES};
    return {1'b0, sum[WIDTH-1:0]};
  endfunction

  // Clamp to zero when the step is larger than the current value.
  function automatic logic [WIDTH:0] sat_down(input logic [WIDTH:0] diff);
    if (diff[WIDTH]) return {1'b1, ALL_ZERO};
    return {1'b0, diff[WIDTH-1:0]};
  endfunction

  // Bounce upward: reaching or passing MAX pins to MAX and signals a reversal.
  function automatic logic [WIDTH:0] bounce_up(input logic [WIDTH:0] sum);
    if (sum >= MAX_X) return {1'b1, ALL_ONES};
    return {1'b0, sum[WIDTH-1:0]};
  endfunction

  // Bounce downward: reaching or passing zero pins to zero and signals a reversal.
  function automatic logic [WIDTH:0] bounce_down(input logic [WIDTH:0] diff);
    if (diff[WIDTH] || (diff[WIDTH-1:0] == ALL_ZERO)) return {1'b1, ALL_ZERO};
    return {1'b0, diff[WIDTH-1:0]};
  endfunction

  logic [WIDTH-1:0] cnt_p1;
  logic             ovf_p1;
  logic             dir_p1;

  logic [WIDTH:0]   step_p0;
  logic [WIDTH:0]   cur_p0;
  logic [WIDTH:0]   sum_p0;
  logic [WIDTH:0]   diff_p0;
  logic [WIDTH:0]   res_p0;
  logic             down_p0;
  logic [WIDTH-1:0] next_cnt_p0;
  logic             next_ovf_p0;
  logic             next_dir_p0;

  // Stage p0: step selection, WIDTH+1-bit sum/difference and policy decision.
  always_comb begin
    step_p0     = ctrl[0] ? STEP_B_X : STEP_A_X;
    cur_p0      = {1'b0, cnt_p1};
    sum_p0      = cur_p0 + step_p0;
    diff_p0     = cur_p0 - step_p0;
    down_p0     = (MODE == MODE_BOUNCE) ? dir_p1 : ctrl[1];
    res_p0      = {1'b0, cnt_p1};
    next_dir_p0 = dir_p1;
    if (MODE == MODE_SAT) begin
      res_p0 = down_p0 ? sat_down(diff_p0) : sat_up(sum_p0);
    end else if (MODE == MODE_BOUNCE) begin
      res_p0 = down_p0 ? bounce_down(diff_p0) : bounce_up(sum_p0);
      if (res_p0[WIDTH]) next_dir_p0 = ~dir_p1;
    end else begin
      res_p0 = down_p0 ? wrap_down(diff_p0) : wrap_up(sum_p0);
    end
    next_cnt_p0 = res_p0[WIDTH-1:0];
    next_ovf_p0 = res_p0[WIDTH];
  end

  // Stage p1: state register; priority reset > load > en > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1 <= INIT_V;
      ovf_p1 <= 1'b0;
      dir_p1 <= 1'b0;
    end else if (load) begin
      cnt_p1 <= load_val;
      ovf_p1 <= 1'b0;
    end else if (en) begin
      cnt_p1 <= next_cnt_p0;
      ovf_p1 <= next_ovf_p0;
      dir_p1 <= next_dir_p0;
    end else begin
      ovf_p1 <= 1'b0;
    end
  end

  assign qout   = cnt_p1;
  assign ovf    = ovf_p1;
  assign dir    = dir_p1;
  assign at_max = (cnt_p1 == ALL_ONES);
  assign at_min = (cnt_p1 == ALL_ZERO);

endmodule
